// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit Harvard CPU control path.
// Contents: opcode encodings, fetch sequencer state enum,
//           branch-kind enum latched between opcode and operand, ALU-op helper.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] OP_NOP  = 8'h00;
  localparam logic [DATA_W-1:0] OP_JMP  = 8'hC0;
  localparam logic [DATA_W-1:0] OP_JZ   = 8'hC1;
  localparam logic [DATA_W-1:0] OP_JC   = 8'hC2;
  localparam logic [DATA_W-1:0] OP_CALL = 8'hC8;
  localparam logic [DATA_W-1:0] OP_RET  = 8'hC9;
  localparam logic [DATA_W-1:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_OPERAND = 2'd2,
    ST_HALTED  = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    BR_JMP  = 2'd0,
    BR_JZ   = 2'd1,
    BR_JC   = 2'd2,
    BR_CALL = 2'd3
  } br_kind_e;

  // Any opcode without a control-flow meaning goes to execute.
  function automatic logic is_alu_op(input logic [DATA_W-1:0] op);
    return !(op inside {OP_NOP, OP_JMP, OP_JZ, OP_JC, OP_CALL, OP_RET, OP_HALT});
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory read data, execute-stage
// handshake and flags, and program-counter enables / load value.
// master: the sequencer (drives PC enables and instruction issue).
// slave : the environment (PC, instruction memory, execute stage).
interface fetch_sequencer_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] imem_data;
  logic              instr_ready;
  logic              exec_idle;
  logic              flag_z;
  logic              flag_c;

  logic              inc_en;
  logic              jmp_en;
  logic              call_en;
  logic              ret_en;
  logic [DATA_W-1:0] ld_count;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;

  modport master (
    input  imem_data, instr_ready, exec_idle, flag_z, flag_c,
    output inc_en, jmp_en, call_en, ret_en, ld_count, instr_valid, instr_data
  );

  modport slave (
    output imem_data, instr_ready, exec_idle, flag_z, flag_c,
    input  inc_en, jmp_en, call_en, ret_en, ld_count, instr_valid, instr_data
  );

endinterface

// File: rtl/fetch_stall_counter.sv
// Saturating count of fetch stall cycles; clears only on reset.
// Ports: clk, rst_n (async active-low), i_stall (count this cycle),
//        o_count (registered count, STALL_CNT_W bits).
module fetch_stall_counter #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_stall,
  output logic [STALL_CNT_W-1:0] o_count
);

  logic [STALL_CNT_W-1:0] r_count;

  // Increment, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_stall && (r_count != '1)) begin
      r_count <= r_count + STALL_CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/branch sequencer: decodes the opcode/operand byte at the current PC,
// drives one-cycle PC enables (Mealy) and issues ALU ops to execute.
// Ports: clk, rst_n (async active-low), run (start, sampled in IDLE),
//        bus (fetch_sequencer_if.master), halted (state is HALTED),
//        stall_cycles (only when FETCH_SEQ_STALL_CNT_EN is defined).
// Macro: FETCH_SEQ_STALL_CNT_EN adds the saturating stall-cycle counter.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  fetch_sequencer_if.master       bus,
  output logic                    halted
`ifdef FETCH_SEQ_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]  stall_cycles
`endif
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  br_kind_e   r_op;
  br_kind_e   w_op_nxt;
  logic       w_cond_flag;

  // State and branch-kind registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= BR_JMP;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
    end
  end

  assign w_cond_flag = (r_op == BR_JZ) ? bus.flag_z : bus.flag_c;

  // Next state and combinational PC enables / issue
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    bus.inc_en      = 1'b0;
    bus.jmp_en      = 1'b0;
    bus.call_en     = 1'b0;
    bus.ret_en      = 1'b0;
    bus.ld_count    = '0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        case (bus.imem_data)
          OP_NOP: begin
            bus.inc_en = 1'b1;
          end
          OP_JMP: begin
            bus.inc_en  = 1'b1;
            w_op_nxt    = BR_JMP;
            w_state_nxt = ST_OPERAND;
          end
          OP_JZ: begin
            bus.inc_en  = 1'b1;
            w_op_nxt    = BR_JZ;
            w_state_nxt = ST_OPERAND;
          end
          OP_JC: begin
            bus.inc_en  = 1'b1;
            w_op_nxt    = BR_JC;
            w_state_nxt = ST_OPERAND;
          end
          OP_CALL: begin
            bus.inc_en  = 1'b1;
            w_op_nxt    = BR_CALL;
            w_state_nxt = ST_OPERAND;
          end
          OP_RET: begin
            bus.ret_en = 1'b1;
          end
          OP_HALT: begin
            w_state_nxt = ST_HALTED;
          end
          default: begin
            // PC holds while not ready, so valid/data stay stable
            bus.instr_valid = 1'b1;
            bus.instr_data  = bus.imem_data;
            bus.inc_en      = bus.instr_ready;
          end
        endcase
      end

      ST_OPERAND: begin
        bus.ld_count = bus.imem_data;
        unique case (r_op)
          BR_JMP: begin
            bus.jmp_en  = 1'b1;
            w_state_nxt = ST_FETCH;
          end
          BR_CALL: begin
            bus.call_en = 1'b1;
            w_state_nxt = ST_FETCH;
          end
          BR_JZ, BR_JC: begin
            // Flags are only final once execute has drained
            if (bus.exec_idle) begin
              bus.jmp_en  = w_cond_flag;
              bus.inc_en  = !w_cond_flag;
              w_state_nxt = ST_FETCH;
            end
          end
        endcase
      end

      ST_HALTED: begin
      end
    endcase
  end

  assign halted = (r_state == ST_HALTED);

`ifdef FETCH_SEQ_STALL_CNT_EN
  logic w_stall;

  assign w_stall = ((r_state == ST_FETCH) && is_alu_op(bus.imem_data) && !bus.instr_ready)
                || ((r_state == ST_OPERAND) && ((r_op == BR_JZ) || (r_op == BR_JC))
                    && !bus.exec_idle);

  fetch_stall_counter #(
    .STALL_CNT_W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_stall (w_stall),
    .o_count (stall_cycles)
  );
`else
  // Width must be at least 1 even when the counter is absent
  if (STALL_CNT_W == 0) begin : g_bad_stall_w
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import cpu_pkg::*;

  localparam int unsigned STALL_CNT_W = 16;
  localparam int MAX_EV   = 60;
  localparam int N_RAND   = 25;

  localparam logic [2:0] EV_INC   = 3'd0;
  localparam logic [2:0] EV_ISSUE = 3'd1;
  localparam logic [2:0] EV_JMP   = 3'd2;
  localparam logic [2:0] EV_CALL  = 3'd3;
  localparam logic [2:0] EV_RET   = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [2:0] kind;
    logic [7:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic halted;
`ifdef FETCH_SEQ_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cycles;
`endif

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .bus    (bus),
    .halted (halted)
`ifdef FETCH_SEQ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Environment: instruction memory and program counter with depth-1 return
  logic [7:0] imem [256];
  logic [7:0] pc;
  logic [7:0] ret_addr;

  assign bus.imem_data = imem[pc];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= 8'h00;
      ret_addr <= 8'h00;
    end else if (bus.inc_en) begin
      pc <= pc + 8'd1;
    end else if (bus.jmp_en) begin
      pc <= bus.ld_count;
    end else if (bus.call_en) begin
      ret_addr <= pc + 8'd1;
      pc       <= bus.ld_count;
    end else if (bus.ret_en) begin
      pc <= ret_addr;
    end
  end

  int  checks = 0;
  int  passes = 0;
  ev_t exp_q[$];
  bit  truncated = 1'b0;
  bit  rand_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Instruction-level reference: walks the program and lists PC-side events
  task automatic model_run(input bit fz, input bit fc, output bit halts);
    logic [7:0] p, p1, ra, op, k;
    bit taken;
    p = 8'h00; ra = 8'h00; halts = 1'b0;
    while (exp_q.size() < MAX_EV) begin
      op = imem[p];
      p1 = p + 8'd1;
      k  = imem[p1];
      if (op == OP_HALT) begin
        halts = 1'b1;
        break;
      end
      if (op == OP_NOP) begin
        exp_q.push_back('{1'b0, EV_INC, 8'h00}); p = p1;
      end else if (op == OP_JMP) begin
        exp_q.push_back('{1'b0, EV_INC, 8'h00});
        exp_q.push_back('{1'b0, EV_JMP, k}); p = k;
      end else if (op == OP_JZ || op == OP_JC) begin
        taken = (op == OP_JZ) ? fz : fc;
        exp_q.push_back('{1'b0, EV_INC, 8'h00});
        if (taken) begin
          exp_q.push_back('{1'b0, EV_JMP, k}); p = k;
        end else begin
          exp_q.push_back('{1'b0, EV_INC, 8'h00}); p = p1 + 8'd1;
        end
      end else if (op == OP_CALL) begin
        exp_q.push_back('{1'b0, EV_INC, 8'h00});
        exp_q.push_back('{1'b0, EV_CALL, k});
        ra = p1 + 8'd1; p = k;
      end else if (op == OP_RET) begin
        exp_q.push_back('{1'b0, EV_RET, 8'h00}); p = ra;
      end else begin
        exp_q.push_back('{1'b1, EV_ISSUE, op}); p = p1;
      end
    end
  endtask

  // Monitor: every cycle with a PC enable is one event for the scoreboard
  ev_t mon_got;
  ev_t mon_exp;
  int  mon_nen;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_nen = int'(bus.inc_en) + int'(bus.jmp_en) + int'(bus.call_en) + int'(bus.ret_en);
      if (mon_nen != 0) begin
        check("enable_onehot", 32'(mon_nen), 32'd1);
        mon_got.valid = bus.instr_valid;
        mon_got.val   = 8'h00;
        if (bus.inc_en && bus.instr_valid) begin
          mon_got.kind = EV_ISSUE; mon_got.val = bus.instr_data;
        end else if (bus.inc_en) begin
          mon_got.kind = EV_INC;
        end else if (bus.jmp_en) begin
          mon_got.kind = EV_JMP; mon_got.val = bus.ld_count;
        end else if (bus.call_en) begin
          mon_got.kind = EV_CALL; mon_got.val = bus.ld_count;
        end else begin
          mon_got.kind = EV_RET;
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("event", 32'(mon_got), 32'(mon_exp));
        end else if (!truncated) begin
          check("unexpected_event", 32'(mon_got), 32'd0);
        end
      end else if (bus.instr_valid && bus.instr_ready) begin
        check("issue_without_inc", 32'(bus.inc_en), 32'd1);
      end
    end
  end

  // Random execute-side backpressure and flag latency
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) begin
        bus.instr_ready = ($urandom_range(0, 3) != 0);
        bus.exec_idle   = ($urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic start_prog(input bit fz, input bit fc, input bit rnd,
                            input bit rdy, input bit idle, output bit halts);
    rst_n = 1'b0;
    rand_en = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    model_run(fz, fc, halts);
    truncated       = !halts;
    bus.flag_z      = fz;
    bus.flag_c      = fc;
    bus.instr_ready = rdy;
    bus.exec_idle   = idle;
    rand_en         = rnd;
    rst_n           = 1'b1;
    run             = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
  endtask

  task automatic finish_prog(input bit halts, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
    if (halts) begin
      repeat (3) @(posedge clk);
      #1;
      check("halted", 32'(halted), 32'd1);
      run = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      run = 1'b0;
      check("halted_ignores_run", 32'(halted), 32'd1);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 8)  return OP_NOP;
    if (r < 12) return OP_JMP;
    if (r < 16) return OP_JZ;
    if (r < 20) return OP_JC;
    if (r < 24) return OP_CALL;
    if (r < 28) return OP_RET;
    if (r < 31) return OP_HALT;
    return 8'($urandom_range(1, 8'hBF));
  endfunction

  function automatic logic [31:0] outs();
    return {8'h00, bus.inc_en, bus.jmp_en, bus.call_en, bus.ret_en, bus.instr_valid,
            halted, 2'b00, bus.ld_count, bus.instr_data};
  endfunction

  bit halts;

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.exec_idle = 1'b0;
    bus.flag_z = 1'b0;
    bus.flag_c = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = OP_NOP;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 32'd0);
`ifdef FETCH_SEQ_STALL_CNT_EN
    check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
`endif

    // NOP, ALU, HALT
    for (int i = 0; i < 256; i++) imem[i] = OP_NOP;
    imem[0] = OP_NOP; imem[1] = 8'h21; imem[2] = OP_HALT;
    start_prog(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, halts);
    finish_prog(halts, 50);

    // JMP 0x40 at PC 5
    for (int i = 0; i < 256; i++) imem[i] = OP_HALT;
    for (int i = 0; i < 5; i++) imem[i] = 8'(8'h10 + i);
    imem[5] = OP_JMP; imem[6] = 8'h40; imem[8'h40] = 8'h55;
    start_prog(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, halts);
    finish_prog(halts, 50);

    // CALL 0x80 at PC 10, RET at 0x80, resume at 12
    for (int i = 0; i < 256; i++) imem[i] = OP_HALT;
    for (int i = 0; i < 10; i++) imem[i] = 8'h11;
    imem[10] = OP_CALL; imem[11] = 8'h80; imem[8'h80] = OP_RET; imem[12] = 8'h66;
    start_prog(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, halts);
    finish_prog(halts, 50);

    // JZ 0x30 with three stall cycles, not taken then taken
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 256; i++) imem[i] = OP_HALT;
      imem[0] = OP_JZ; imem[1] = 8'h30; imem[2] = 8'h22; imem[8'h30] = 8'h33;
      start_prog(t[0], 1'b0, 1'b0, 1'b1, 1'b0, halts);
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("stall_no_enables", {28'd0, bus.inc_en, bus.jmp_en, bus.call_en, bus.ret_en}, 32'd0);
      end
      @(posedge clk);
      #1;
      bus.exec_idle = 1'b1;
      finish_prog(halts, 50);
`ifdef FETCH_SEQ_STALL_CNT_EN
      check("jz_stall_cycles", 32'(stall_cycles), 32'd3);
`endif
    end

    // ALU op held by instr_ready low for four cycles
    for (int i = 0; i < 256; i++) imem[i] = OP_HALT;
    imem[0] = 8'h21;
    start_prog(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, halts);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("alu_hold", {22'd0, bus.instr_valid, bus.instr_data, bus.inc_en}, {22'd0, 1'b1, 8'h21, 1'b0});
    end
    @(posedge clk);
    #1;
    bus.instr_ready = 1'b1;
    finish_prog(halts, 50);
`ifdef FETCH_SEQ_STALL_CNT_EN
    check("alu_stall_cycles", 32'(stall_cycles), 32'd4);
`endif

    // Reset while in OPERAND abandons the branch
    for (int i = 0; i < 256; i++) imem[i] = OP_NOP;
    imem[0] = OP_JMP; imem[1] = 8'h40;
    start_prog(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, halts);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_in_operand", outs(), 32'd0);
    exp_q.delete();
    truncated = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("idle_after_reset", outs(), 32'd0);
    end

    // Random programs with random backpressure, flag latency and flags
    for (int p = 0; p < N_RAND; p++) begin
      for (int i = 0; i < 256; i++) imem[i] = rand_byte();
      start_prog(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, halts);
      finish_prog(halts, 2000);
    end

    rand_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
